// File: rtl/alu_drive_check.sv
// Driver/checker for the TinyALU: accepts ops on valid/ready, drives start/op/A/B, checks result.
// Optional coverage bits (cov_op_hit, cov_corner, cov_done) are compiled in with `define ALU_COVERAGE_EN.
module alu_drive_check #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             start,
  output logic [2:0]       op,
  output logic [7:0]       A,
  output logic [7:0]       B,
  input  logic             done,
  input  logic [15:0]      result,
  output logic             res_valid,
  output logic [15:0]      res_actual,
  output logic [15:0]      res_expected,
  output logic             res_mismatch,
  output logic             res_timeout,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             illegal_op,
  output logic             spurious_done,
  output logic [4:0]       cov_op_hit,
  output logic [3:0]       cov_corner,
  output logic             cov_done
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int          TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tcount;
  logic [15:0]   predicted;
  logic          accept;
  logic          alu_code;

  assign accept   = op_valid & op_ready & (state == IDLE);
  assign alu_code = (op_code >= 3'd1) && (op_code <= 3'd4);

  // Prediction is formed from the registered op/A/B, so it is stable for the whole transaction.
  always_comb begin
    predicted = '0;
    case (op)
      3'd1:    predicted = 16'(A) + 16'(B);
      3'd2:    predicted = 16'(A & B);
      3'd3:    predicted = 16'(A ^ B);
      3'd4:    predicted = 16'(A) * 16'(B);
      default: predicted = '0;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Single FSM; op_ready is registered so it first rises one edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tcount        <= '0;
      op_ready      <= 1'b0;
      start         <= 1'b0;
      op            <= '0;
      A             <= '0;
      B             <= '0;
      res_valid     <= 1'b0;
      res_actual    <= '0;
      res_expected  <= '0;
      res_mismatch  <= 1'b0;
      res_timeout   <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      illegal_op    <= 1'b0;
      spurious_done <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          op_ready <= 1'b1;
          if (done)
            spurious_done <= 1'b1;
          if (accept) begin
            if (alu_code) begin
              op       <= op_code;
              A        <= op_a;
              B        <= op_b;
              start    <= 1'b1;
              op_ready <= 1'b0;
              tcount   <= '0;
              state    <= BUSY;
            end else if (op_code >= 3'd5) begin
              illegal_op <= 1'b1;
            end
          end
        end
        BUSY: begin
          // done is checked first so it wins over a simultaneous timeout expiry
          if (done) begin
            start        <= 1'b0;
            op_ready     <= 1'b1;
            state        <= IDLE;
            res_valid    <= 1'b1;
            res_actual   <= result;
            res_expected <= predicted;
            res_mismatch <= (result != predicted);
            res_timeout  <= 1'b0;
            if (result != predicted)
              err_count <= sat_inc(err_count);
            else
              pass_count <= sat_inc(pass_count);
          end else if (tcount == TLAST) begin
            start        <= 1'b0;
            op_ready     <= 1'b1;
            state        <= IDLE;
            res_valid    <= 1'b1;
            res_actual   <= '0;
            res_expected <= predicted;
            res_mismatch <= 1'b1;
            res_timeout  <= 1'b1;
            err_count    <= sat_inc(err_count);
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_COVERAGE_EN
  // Coverage is sampled on every accepted op, including the ones that never reach the ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cov_op_hit <= '0;
      cov_corner <= '0;
    end else if (accept) begin
      case (op_code)
        3'd0:    cov_op_hit[0] <= 1'b1;
        3'd1:    cov_op_hit[1] <= 1'b1;
        3'd2:    cov_op_hit[2] <= 1'b1;
        3'd3:    cov_op_hit[3] <= 1'b1;
        3'd4:    cov_op_hit[4] <= 1'b1;
        default: cov_op_hit <= cov_op_hit;
      endcase
      if (alu_code) begin
        if (op_a == 8'h00) cov_corner[0] <= 1'b1;
        if (op_a == 8'hFF) cov_corner[1] <= 1'b1;
        if (op_b == 8'h00) cov_corner[2] <= 1'b1;
        if (op_b == 8'hFF) cov_corner[3] <= 1'b1;
      end
    end
  end

  assign cov_done = (&cov_op_hit) & (&cov_corner);
`else
  assign cov_op_hit = '0;
  assign cov_corner = '0;
  assign cov_done   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_drive_check.sv
// Testbench for alu_drive_check: directed test-plan steps followed by randomized transactions,
// checked against a behavioural model of the expected results, counters and sticky flags.
module tb_alu_drive_check;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
`ifdef ALU_COVERAGE_EN
  localparam bit COV_EN = 1'b1;
`else
  localparam bit COV_EN = 1'b0;
`endif

  logic             clk, reset;
  logic             op_valid, op_ready;
  logic [2:0]       op_code;
  logic [7:0]       op_a, op_b;
  logic             start;
  logic [2:0]       op;
  logic [7:0]       A, B;
  logic             done;
  logic [15:0]      result;
  logic             res_valid;
  logic [15:0]      res_actual, res_expected;
  logic             res_mismatch, res_timeout;
  logic [CNT_W-1:0] pass_count, err_count;
  logic             illegal_op, spurious_done;
  logic [4:0]       cov_op_hit;
  logic [3:0]       cov_corner;
  logic             cov_done;

  alu_drive_check #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .start(start), .op(op), .A(A), .B(B), .done(done), .result(result),
    .res_valid(res_valid), .res_actual(res_actual), .res_expected(res_expected),
    .res_mismatch(res_mismatch), .res_timeout(res_timeout),
    .pass_count(pass_count), .err_count(err_count),
    .illegal_op(illegal_op), .spurious_done(spurious_done),
    .cov_op_hit(cov_op_hit), .cov_corner(cov_corner), .cov_done(cov_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_pass, m_err;
  bit         m_illegal, m_spurious;
  logic [4:0] m_op_hit;
  logic [3:0] m_corner;

  function automatic logic [15:0] refPredict(input int code, input int a, input int b);
    case (code)
      1:       return 16'(a + b);
      2:       return 16'(a & b);
      3:       return 16'(a ^ b);
      4:       return 16'(a * b);
      default: return 16'd0;
    endcase
  endfunction

  function automatic int satInc(input int v);
    return (v < (1 << CNT_W) - 1) ? v + 1 : v;
  endfunction

  task automatic modelReset();
    m_pass = 0; m_err = 0; m_illegal = 0; m_spurious = 0;
    m_op_hit = '0; m_corner = '0;
  endtask

  task automatic modelAccept(input int code, input int a, input int b);
    if (code <= 4) m_op_hit[code] = 1'b1;
    if (code >= 5) m_illegal = 1'b1;
    if (code >= 1 && code <= 4) begin
      if (a == 0)   m_corner[0] = 1'b1;
      if (a == 255) m_corner[1] = 1'b1;
      if (b == 0)   m_corner[2] = 1'b1;
      if (b == 255) m_corner[3] = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag);
    logic [4:0] eh;
    logic [3:0] ec;
    eh = COV_EN ? m_op_hit : 5'd0;
    ec = COV_EN ? m_corner : 4'd0;
    checkOutput({tag, "_pass_count"}, pass_count, CNT_W'(m_pass));
    checkOutput({tag, "_err_count"}, err_count, CNT_W'(m_err));
    checkOutput({tag, "_illegal_op"}, illegal_op, m_illegal);
    checkOutput({tag, "_spurious_done"}, spurious_done, m_spurious);
    checkOutput({tag, "_cov_op_hit"}, cov_op_hit, eh);
    checkOutput({tag, "_cov_corner"}, cov_corner, ec);
    checkOutput({tag, "_cov_done"}, cov_done, (&eh) & (&ec));
  endtask

  // Presents one op and returns at the negedge just after it was accepted.
  task automatic applyStimulus(input int code, input int a, input int b);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!op_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!op_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_wait observed=0 expected=1");
    end
    op_valid = 1'b1;
    op_code  = 3'(code);
    op_a     = 8'(a);
    op_b     = 8'(b);
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'(urandom_pick());
    modelAccept(code, a, b);
  endtask

  function automatic int urandom_pick();
    return int'($urandom_range(0, 7));
  endfunction

  // latency 0 means the ALU never answers; otherwise done comes 'latency' cycles after start.
  task automatic runTxn(input int code, input int a, input int b, input int latency,
                        input logic [15:0] ret, input string tag);
    logic [15:0] exp;
    int held;
    applyStimulus(code, a, b);
    held = 0;
    if (code >= 1 && code <= 4) begin
      exp = refPredict(code, a, b);
      checkOutput({tag, "_op"}, op, code);
      checkOutput({tag, "_A"}, A, a);
      checkOutput({tag, "_B"}, B, b);
      if (latency == 0) begin
        while (start && held < TIMEOUT + 8) begin
          held++;
          @(negedge clk);
        end
        m_err = satInc(m_err);
        checkOutput({tag, "_start_held"}, held, TIMEOUT);
        checkOutput({tag, "_res_timeout"}, res_timeout, 1);
        checkOutput({tag, "_res_actual"}, res_actual, 0);
        checkOutput({tag, "_res_mismatch"}, res_mismatch, 1);
      end else begin
        for (int i = 1; i < latency; i++) begin
          if (start) held++;
          @(negedge clk);
        end
        if (start) held++;
        done   = 1'b1;
        result = ret;
        @(negedge clk);
        done   = 1'b0;
        result = 16'($urandom);
        if (ret != exp) m_err = satInc(m_err);
        else            m_pass = satInc(m_pass);
        checkOutput({tag, "_start_held"}, held, latency);
        checkOutput({tag, "_res_timeout"}, res_timeout, 0);
        checkOutput({tag, "_res_actual"}, res_actual, ret);
        checkOutput({tag, "_res_mismatch"}, res_mismatch, ret != exp);
      end
      checkOutput({tag, "_res_valid"}, res_valid, 1);
      checkOutput({tag, "_res_expected"}, res_expected, exp);
      checkOutput({tag, "_start_low"}, start, 0);
      checkOutput({tag, "_op_ready"}, op_ready, 1);
      checkStatus(tag);
      @(negedge clk);
      checkOutput({tag, "_res_valid_pulse"}, res_valid, 0);
    end else begin
      checkOutput({tag, "_no_start"}, start, 0);
      checkOutput({tag, "_no_res_valid"}, res_valid, 0);
      checkOutput({tag, "_op_ready"}, op_ready, 1);
      checkStatus(tag);
    end
  endtask

  function automatic int pickOperand();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int code, a, b, lat;
    logic [15:0] ret;
    reset = 1'b0; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0;
    done = 1'b0; result = '0;
    modelReset();
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_op_ready", op_ready, 0);
    checkOutput("reset_start", start, 0);
    checkOutput("reset_res_valid", res_valid, 0);
    checkStatus("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_op_ready", op_ready, 1);

    $display("[TB] directed test-plan steps");
    runTxn(1, 8'hFF, 8'h01, 1, 16'h0100, "add_ff_01");
    runTxn(4, 8'hFF, 8'hFF, 3, 16'hFE01, "mul_ff_ff");
    runTxn(3, 8'hA5, 8'h0F, 1, 16'h00AB, "xor_bad");
    runTxn(1, 8'h10, 8'h20, 0, 16'h0000, "add_timeout");
    runTxn(2, 8'hF0, 8'h3C, TIMEOUT, 16'h0030, "and_done_at_limit");
    runTxn(0, 8'h12, 8'h34, 1, 16'h0000, "noop");
    runTxn(6, 8'h56, 8'h78, 1, 16'h0000, "illegal6");

    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    m_spurious = 1'b1;
    checkOutput("spurious_no_res_valid", res_valid, 0);
    checkOutput("spurious_no_start", start, 0);
    checkStatus("spurious");

    applyStimulus(4, 8'hFF, 8'h02);
    checkOutput("mid_mul_start", start, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset_start", start, 0);
    checkOutput("async_reset_op_ready", op_ready, 0);
    checkOutput("async_reset_res_valid", res_valid, 0);
    checkStatus("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("release_op_ready_low", op_ready, 0);
    @(negedge clk);
    checkOutput("release_op_ready_high", op_ready, 1);
    runTxn(1, 3, 4, 1, 16'h0007, "add_3_4");

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      code = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 7));
      a    = pickOperand();
      b    = pickOperand();
      lat  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 6));
      ret  = refPredict(code, a, b);
      if ($urandom_range(0, 3) == 0) ret = ret ^ 16'($urandom_range(1, 65535));
      runTxn(code, a, b, lat, ret, $sformatf("rand%0d", n));
    end

    @(negedge clk);
    checkStatus("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
